bp_mac_seq: RTL

//  Sequencer for the shared backprop MAC that turns LSTM delta gates into dX / delta-Out vectors.
//  For each output j it sums dgate[g][k] * W[g][k][j] over cells k and gates a,i,f,o (g=0..3).
//  It drives the dgate mux select, weight mux select, memory read addresses, MAC clear/accumulate and result-memory writes.
//  It sits beside the bp datapath; the top-level control FSM issues start and waits for done.

---
 rtl/bp_mac_seq_if.sv | 29 ++
 rtl/bp_mac_seq.sv | 126 ++++++++++++
 2 files changed

// File: rtl/bp_mac_seq_if.sv
// rtl/bp_mac_seq_if.sv - control/address bundle between the bp MAC sequencer and its surroundings
interface bp_mac_seq_if #(
  parameter int AW = 12
);
  logic          start;
  logic          abort;
  logic          busy;
  logic          done;
  logic [1:0]    sel_dgate;
  logic [1:0]    sel_wghts;
  logic [AW-1:0] rd_addr_dgate;
  logic [AW-1:0] rd_addr_wght;
  logic          rst_mac;
  logic          acc_mac;
  logic          wr_en;
  logic [AW-1:0] wr_addr;

  modport master (
    input  start, abort,
    output busy, done, sel_dgate, sel_wghts, rd_addr_dgate, rd_addr_wght,
           rst_mac, acc_mac, wr_en, wr_addr
  );

  modport slave (
    output start, abort,
    input  busy, done, sel_dgate, sel_wghts, rd_addr_dgate, rd_addr_wght,
           rst_mac, acc_mac, wr_en, wr_addr
  );
endinterface

// File: rtl/bp_mac_seq.sv
// rtl/bp_mac_seq.sv - sequences the shared backprop MAC: sum over gates and cells of dgate*W per output
module bp_mac_seq #(
  parameter int N_OUT   = 53,
  parameter int N_IN    = 8,
  parameter int RD_LAT  = 1,
  parameter int MAC_LAT = 1,
  parameter int AW      = 12
) (
  input logic           clk,
  input logic           rst,
  bp_mac_seq_if.master  bus
);
  localparam int DW = $clog2(RD_LAT + MAC_LAT + 1);

  typedef enum logic [2:0] {IDLE, CLR, RUN, DRAIN, WRITE, DONE} state_t;

  state_t        state, next_state;
  logic [1:0]    g;
  logic [AW-1:0] k;
  logic [AW-1:0] wght_addr;
  logic [AW-1:0] j;
  logic [AW-1:0] base;
  logic [DW-1:0] drain_cnt;
  logic [RD_LAT-1:0] run_dly;

  logic last_term, last_out, drain_end, kill;

  assign last_term = (g == 2'd3) && (k == AW'(N_IN - 1));
  assign last_out  = (j == AW'(N_OUT - 1));
  assign drain_end = (drain_cnt == DW'(RD_LAT + MAC_LAT - 1));
  assign kill      = bus.abort && (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (bus.abort) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.start) next_state = CLR;
        CLR:     next_state = RUN;
        RUN:     if (last_term) next_state = DRAIN;
        DRAIN:   if (drain_end) next_state = WRITE;
        WRITE:   next_state = last_out ? DONE : CLR;
        DONE:    next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // Term counters double as the registered address/select outputs, so they
  // simply stop on the last term and hold until the next output's RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g         <= '0;
      k         <= '0;
      wght_addr <= '0;
      j         <= '0;
      base      <= '0;
      drain_cnt <= '0;
    end else if (kill) begin
      g         <= '0;
      k         <= '0;
      wght_addr <= '0;
      j         <= '0;
      base      <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        CLR: begin
          g         <= '0;
          k         <= '0;
          wght_addr <= base;
          drain_cnt <= '0;
        end
        RUN: begin
          if (!last_term) begin
            if (g == 2'd3) begin
              g         <= '0;
              k         <= k + AW'(1);
              wght_addr <= wght_addr + AW'(1);
            end else begin
              g <= g + 2'd1;
            end
          end
        end
        DRAIN: drain_cnt <= drain_cnt + DW'(1);
        WRITE: begin
          if (last_out) begin
            j    <= '0;
            base <= '0;
          end else begin
            j    <= j + AW'(1);
            base <= base + AW'(N_IN);
          end
        end
        default: ;
      endcase
    end
  end

  // Aligns the accumulate enable with memory data arriving RD_LAT cycles later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       run_dly <= '0;
    else if (kill) run_dly <= '0;
    else           run_dly <= (run_dly << 1) | RD_LAT'(state == RUN);
  end

  always_comb begin
    bus.busy    = (state != IDLE);
    bus.done    = (state == DONE);
    bus.rst_mac = (state == CLR);
    bus.wr_en   = (state == WRITE);
  end

  assign bus.sel_dgate     = g;
  assign bus.sel_wghts     = g;
  assign bus.rd_addr_dgate = k;
  assign bus.rd_addr_wght  = wght_addr;
  assign bus.wr_addr       = j;
  assign bus.acc_mac       = run_dly[RD_LAT-1];
endmodule
